// File: rtl/exp_seq_if.sv
// Start/busy/done handshake and data bundle for the exp_seq evaluator.
// The master drives start and x_in. The slave returns busy, done and f_out.
interface exp_seq_if #(
    parameter int W = 17
);
    logic              start;
    logic signed [W:0] x_in;
    logic              busy;
    logic              done;
    logic signed [W:0] f_out;

    modport master (output start, x_in, input busy, done, f_out);
    modport slave  (input start, x_in, output busy, done, f_out);
endinterface

// File: rtl/exp_seq.sv
// e^x by degree-5 Horner evaluation with one shared multiplier (Q0.16 in, Q3.15 out); optional EXP_ROUND_EN rounds each step half-up.
// Latency is 5 cycles from the accepted start edge to done. Throughput is 1 result per 6 cycles.
// There is no backpressure. start is sampled only in IDLE, and starts seen while busy are dropped.
module exp_seq #(
    parameter int N = 5,
    parameter int W = 17
) (
    input  logic     clk,
    input  logic     reset,
    exp_seq_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic signed [W:0]   x_r, x_nxt;
    logic signed [W:0]   s_r, s_nxt;
    logic signed [W:0]   f_r, f_nxt;
    logic [2:0]          k_r, k_nxt;
    logic                done_r, done_nxt;
    logic signed [W:0]   coeff;
    logic signed [W:0]   step;
    logic signed [2*W+1:0] prod;
    logic signed [2*W+1:0] prod_adj;

    // Taylor coefficients 1/k! scaled by 32768; the index is the Horner step counter.
    function automatic logic signed [W:0] coef(input logic [2:0] idx);
        case (idx)
            3'd0:    coef = (W+1)'(32768);
            3'd1:    coef = (W+1)'(32768);
            3'd2:    coef = (W+1)'(16384);
            3'd3:    coef = (W+1)'(5461);
            3'd4:    coef = (W+1)'(1365);
            default: coef = (W+1)'(273);
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        x_nxt     = x_r;
        s_nxt     = s_r;
        k_nxt     = k_r;
        f_nxt     = f_r;
        done_nxt  = 1'b0;

        coeff = coef(k_r);
        prod  = x_r * s_r;
`ifdef EXP_ROUND_EN
        prod_adj = prod + (2*W+2)'(32768);
`else
        prod_adj = prod;
`endif
        // The arithmetic shift floors. The sum wraps to the datapath width.
        step = (W+1)'(prod_adj >>> 16) + coeff;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    x_nxt     = bus.x_in;
                    s_nxt     = coef(3'(N));
                    k_nxt     = 3'(N - 1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (k_r != 3'd0) begin
                    s_nxt = step;
                    k_nxt = k_r - 3'd1;
                end else begin
                    f_nxt     = step;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            x_r    <= '0;
            s_r    <= '0;
            k_r    <= '0;
            f_r    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            x_r    <= x_nxt;
            s_r    <= s_nxt;
            k_r    <= k_nxt;
            f_r    <= f_nxt;
            done_r <= done_nxt;
        end
    end

    assign bus.busy  = (state == BUSY);
    assign bus.done  = done_r;
    assign bus.f_out = f_r;
endmodule
